// File: rtl/cp0_timer_exc.sv
// MIPS CP0 block: BadVAddr, Count, Compare, Status, Cause, EPC,
// Count/Compare timer, interrupt sampler, exception/ERET redirect.
//
// Ports: clk, restn (async active-low); mtc0_we/addr/wdata write port;
// mfc0_addr/rdata read port with write bypass; exc_* commit strobe;
// hw_int interrupts; int_pending, flush, flush_target; register views.
module cp0_timer_exc #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                  clk,
  input  logic                  restn,
  input  logic                  mtc0_we,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_wdata,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_rdata,
  input  logic                  exc_valid,
  input  logic                  exc_is_eret,
  input  logic [4:0]            exc_code,
  input  logic                  exc_in_ds,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bad_vld,
  input  logic [31:0]           exc_badvaddr,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_pending,
  output logic                  flush,
  output logic [31:0]           flush_target,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic [31:0]           badvaddr_o,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o
);

  localparam logic [31:0] ST_MASK = 32'h0000_FF03;
  localparam logic [31:0] CA_MASK = 32'h0000_0300;
  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(COUNT_DIV - 1);

  logic [31:0]   badvaddr_q;
  logic [31:0]   count_q;
  logic [31:0]   compare_q;
  logic [31:0]   status_q;
  logic [31:0]   epc_q;
  logic          bd_q;
  logic          ti_q;
  logic [5:0]    hw_q;
  logic [1:0]    sw_q;
  logic [4:0]    code_q;
  logic [DW-1:0] div_q;

  logic        exc;
  logic        eret;
  logic        mw;
  logic        wr_cnt;
  logic        wr_cmp;
  logic        wr_st;
  logic        wr_ca;
  logic        wr_epc;
  logic        div_wrap;
  logic        tick;
  logic        hit;
  logic        byp;
  logic [31:0] count_inc;
  logic [31:0] st_merge;
  logic [31:0] ca_merge;
  logic [5:0]  hw_ext;

  assign exc  = exc_valid & ~exc_is_eret;
  assign eret = exc_valid & exc_is_eret;
  // A committing exception swallows any MTC0 in the same cycle.
  assign mw   = mtc0_we & ~exc_valid;

  assign wr_cnt = mw & (mtc0_addr == 5'd9);
  assign wr_cmp = mw & (mtc0_addr == 5'd11);
  assign wr_st  = mw & (mtc0_addr == 5'd12);
  assign wr_ca  = mw & (mtc0_addr == 5'd13);
  assign wr_epc = mw & (mtc0_addr == 5'd14);

  assign div_wrap  = (div_q == DIV_LAST);
  assign count_inc = count_q + 32'd1;
  assign tick      = ~wr_cnt & div_wrap;
  assign hit       = tick & (count_inc == compare_q);

  assign hw_ext = 6'(hw_int);

  assign cause_o = {bd_q, ti_q, 14'd0,
                    hw_q[5] | ti_q, hw_q[4:0],
                    sw_q, 1'b0, code_q, 2'b00};

  assign status_o   = status_q;
  assign epc_o      = epc_q;
  assign badvaddr_o = badvaddr_q;
  assign count_o    = count_q;
  assign compare_o  = compare_q;

  assign int_pending = status_q[0] & ~status_q[1] &
                       (|(cause_o[15:8] & status_q[15:8]));

  assign flush        = exc_valid;
  assign flush_target = exc_is_eret ? epc_q : EXC_VECTOR;

  assign st_merge = (status_q & ~ST_MASK) | (mtc0_wdata & ST_MASK);
  assign ca_merge = (cause_o & ~CA_MASK) | (mtc0_wdata & CA_MASK);
  assign byp      = mw & (mtc0_addr == mfc0_addr);

  always_comb begin
    mfc0_rdata = 32'd0;
    case (mfc0_addr)
      5'd8:    mfc0_rdata = badvaddr_q;
      5'd9:    mfc0_rdata = byp ? mtc0_wdata : count_q;
      5'd11:   mfc0_rdata = byp ? mtc0_wdata : compare_q;
      5'd12:   mfc0_rdata = byp ? st_merge : status_q;
      5'd13:   mfc0_rdata = byp ? ca_merge : cause_o;
      5'd14:   mfc0_rdata = byp ? mtc0_wdata : epc_q;
      default: mfc0_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      status_q   <= STATUS_RST;
      epc_q      <= 32'd0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      hw_q       <= 6'd0;
      sw_q       <= 2'd0;
      code_q     <= 5'd0;
      div_q      <= '0;
    end else begin
      hw_q <= hw_ext;

      if (wr_cnt) begin
        count_q <= mtc0_wdata;
        div_q   <= '0;
      end else if (div_wrap) begin
        count_q <= count_inc;
        div_q   <= '0;
      end else begin
        div_q <= div_q + DW'(1);
      end

      // Compare write beats a same-cycle match.
      if (wr_cmp) begin
        compare_q <= mtc0_wdata;
        ti_q      <= 1'b0;
      end else if (hit) begin
        ti_q <= 1'b1;
      end

      if (exc) begin
        status_q[1] <= 1'b1;
      end else if (eret) begin
        status_q[1] <= 1'b0;
      end else if (wr_st) begin
        status_q <= st_merge;
      end

      if (wr_ca) begin
        sw_q <= mtc0_wdata[9:8];
      end

      if (wr_epc) begin
        epc_q <= mtc0_wdata;
      end

      if (exc) begin
        code_q <= exc_code;
        // Nested exception keeps the original return point.
        if (!status_q[1]) begin
          epc_q <= exc_in_ds ? exc_pc - 32'd4 : exc_pc;
          bd_q  <= exc_in_ds;
        end
        if (exc_bad_vld) begin
          badvaddr_q <= exc_badvaddr;
        end
      end
    end
  end

endmodule
